mem_stage: RTL and testbench

- Pipeline stage between the ALU stage and the register-write stage of the 16-bit core.
- Performs load/store accesses over a req/ack data-memory bus and stalls upstream while an access is outstanding.
- Presents one registered result per instruction (valid, reg_write byte enables, reg_dest, data, setPC) to the register-write stage; non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_stage.sv | 154 +++++++++++++++
 tb/tb_mem_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline stage between ALU and register-write for the 16-bit core.
// Issues loads/stores on a req/ack data-memory bus and stalls upstream
// (ready_o low) while an access is outstanding. Every instruction yields one
// registered single-cycle valid_o pulse carrying its write-back result.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   valid_i / ready_o     upstream handshake (ready_o = stage idle)
//   mem_read_i, mem_write_i, byte_i, addr_i, store_data_i
//                         access description from the ALU stage
//   reg_write_i, reg_dest_i, setPC_i
//                         write-back control carried alongside the access
//   mem_addr, mem_wdata, mem_be, mem_we, mem_req
//                         registered bus request (held while mem_req=1)
//   mem_ack, mem_rdata    bus response (rdata valid with ack)
//   valid_o, reg_write_o, reg_dest_o, data_out_o, setPC_o, fault_o
//                         registered result to the register-write stage
module mem_stage #(
  parameter int TIMEOUT = 16,  // BUS cycles without ack before abort; 0 = never
  parameter int TCW     = 5    // timeout counter width, 2^TCW > TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic        byte_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] store_data_i,
  input  logic [1:0]  reg_write_i,
  input  logic [3:0]  reg_dest_i,
  input  logic        setPC_i,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        valid_o,
  output logic [1:0]  reg_write_o,
  output logic [3:0]  reg_dest_o,
  output logic [15:0] data_out_o,
  output logic        setPC_o,
  output logic        fault_o
);

  typedef enum logic {IDLE, BUS} state_t;

  // Counter value on the edge that completes the TIMEOUT-th BUS cycle.
  localparam logic [TCW-1:0] LIMIT = TCW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t         state;
  logic [TCW-1:0] wait_cnt;
  logic [15:0]    addr_cap;      // raw (unaligned) address of the access
  logic           byte_cap;
  logic [1:0]     reg_write_cap;
  logic [3:0]     reg_dest_cap;
  logic           setpc_cap;

  logic           is_mem;
  logic           limit_hit;
  logic [7:0]     lane;
  logic [15:0]    load_data;

  assign ready_o   = (state == IDLE);
  assign is_mem    = mem_read_i | mem_write_i;
  assign limit_hit = (TIMEOUT > 0) && (wait_cnt == LIMIT);

  // Byte loads take the lane addressed by bit 0 and zero-extend it.
  assign lane      = addr_cap[0] ? mem_rdata[15:8] : mem_rdata[7:0];
  assign load_data = byte_cap ? {8'h00, lane} : mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      addr_cap      <= '0;
      byte_cap      <= 1'b0;
      reg_write_cap <= '0;
      reg_dest_cap  <= '0;
      setpc_cap     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      mem_we        <= 1'b0;
      mem_req       <= 1'b0;
      valid_o       <= 1'b0;
      reg_write_o   <= '0;
      reg_dest_o    <= '0;
      data_out_o    <= '0;
      setPC_o       <= 1'b0;
      fault_o       <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            if (is_mem) begin
              state         <= BUS;
              wait_cnt      <= '0;
              mem_req       <= 1'b1;
              // A set write bit makes it a store even if read is also set.
              mem_we        <= mem_write_i;
              mem_addr      <= byte_i ? addr_i : {addr_i[15:1], 1'b0};
              mem_be        <= byte_i ? (addr_i[0] ? 2'b10 : 2'b01) : 2'b11;
              mem_wdata     <= byte_i ? {store_data_i[7:0], store_data_i[7:0]}
                                      : store_data_i;
              addr_cap      <= addr_i;
              byte_cap      <= byte_i;
              reg_write_cap <= reg_write_i;
              reg_dest_cap  <= reg_dest_i;
              setpc_cap     <= setPC_i;
            end else begin
              valid_o     <= 1'b1;
              data_out_o  <= addr_i;
              reg_write_o <= reg_write_i;
              reg_dest_o  <= reg_dest_i;
              setPC_o     <= setPC_i;
              fault_o     <= 1'b0;
            end
          end
        end
        BUS: begin
          // Ack is checked first so an ack on the limit edge completes normally.
          if (mem_ack) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            valid_o     <= 1'b1;
            fault_o     <= 1'b0;
            reg_write_o <= reg_write_cap;
            reg_dest_o  <= reg_dest_cap;
            setPC_o     <= setpc_cap;
            data_out_o  <= mem_we ? addr_cap : load_data;
          end else if (limit_hit) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            valid_o     <= 1'b1;
            fault_o     <= 1'b1;
            reg_write_o <= 2'b00;
            reg_dest_o  <= reg_dest_cap;
            setPC_o     <= 1'b0;
            data_out_o  <= addr_cap;
          end else begin
            wait_cnt <= wait_cnt + TCW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of directed transactions, random
// transactions checked against a behavioural model, and hand sequences for
// reset-during-access and stray acks.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, ready_o, mem_read_i, mem_write_i, byte_i;
  logic [15:0] addr_i, store_data_i;
  logic [1:0]  reg_write_i;
  logic [3:0]  reg_dest_i;
  logic        setPC_i;
  logic [15:0] mem_addr, mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_we, mem_req, mem_ack;
  logic [15:0] mem_rdata;
  logic        valid_o;
  logic [1:0]  reg_write_o;
  logic [3:0]  reg_dest_o;
  logic [15:0] data_out_o;
  logic        setPC_o, fault_o;

  int checks = 0;
  int failures = 0;

  mem_stage #(.TIMEOUT(TO), .TCW(5)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .byte_i(byte_i),
    .addr_i(addr_i), .store_data_i(store_data_i), .reg_write_i(reg_write_i),
    .reg_dest_i(reg_dest_i), .setPC_i(setPC_i), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .valid_o(valid_o),
    .reg_write_o(reg_write_o), .reg_dest_o(reg_dest_o), .data_out_o(data_out_o),
    .setPC_o(setPC_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    bit          byt;
    logic [15:0] addr;
    logic [15:0] sdata;
    logic [1:0]  rw;
    logic [3:0]  dest;
    bit          spc;
    int          ack_at;   // BUS cycle carrying ack (1 = first); 0 = never
    logic [15:0] rdata;
    int          e_lat;    // edges from acceptance to valid_o
    logic [15:0] e_data;
    logic [1:0]  e_rw;
    bit          e_spc;
    bit          e_fault;
    logic [15:0] e_maddr;
    logic [1:0]  e_be;
    logic [15:0] e_wdata;
    bit          e_we;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: derives expectations from the instruction alone.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int bus_cycles;
    r.e_maddr = 16'h0; r.e_be = 2'b00; r.e_wdata = 16'h0; r.e_we = 1'b0;
    r.e_fault = 1'b0;
    if (!(v.rd || v.wr)) begin
      r.e_lat = 1; r.e_data = v.addr; r.e_rw = v.rw; r.e_spc = v.spc;
      return r;
    end
    r.e_we    = v.wr;
    r.e_maddr = v.byt ? v.addr : (v.addr & 16'hFFFE);
    r.e_be    = v.byt ? 2'(1 << v.addr[0]) : 2'd3;
    r.e_wdata = v.byt ? 16'(v.sdata[7:0] * 16'h0101) : v.sdata;
    if (v.ack_at >= 1 && v.ack_at <= TO) begin
      bus_cycles = v.ack_at;
      r.e_rw  = v.rw;
      r.e_spc = v.spc;
      if (v.wr)
        r.e_data = v.addr;
      else if (v.byt)
        r.e_data = (v.rdata >> (8 * int'(v.addr[0]))) & 16'h00FF;
      else
        r.e_data = v.rdata;
    end else begin
      bus_cycles = TO;
      r.e_fault = 1'b1; r.e_rw = 2'b00; r.e_spc = 1'b0; r.e_data = 16'h0;
    end
    r.e_lat = 1 + bus_cycles;
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int  lat;
    bit  got;
    bit  is_mem;
    is_mem = v.rd || v.wr;
    check({tag, ".ready_before"}, 32'(ready_o), 32'd1);
    valid_i = 1'b1; mem_read_i = v.rd; mem_write_i = v.wr; byte_i = v.byt;
    addr_i = v.addr; store_data_i = v.sdata; reg_write_i = v.rw;
    reg_dest_i = v.dest; setPC_i = v.spc;
    step();
    valid_i = 1'b0;
    addr_i = 16'($urandom); store_data_i = 16'($urandom);
    lat = 1;
    got = valid_o;
    if (is_mem) begin
      check({tag, ".req"}, 32'(mem_req), 32'd1);
      check({tag, ".ready_lo"}, 32'(ready_o), 32'd0);
      check({tag, ".early_valid"}, 32'(valid_o), 32'd0);
      check({tag, ".mem_addr"}, 32'(mem_addr), 32'(v.e_maddr));
      check({tag, ".mem_be"}, 32'(mem_be), 32'(v.e_be));
      check({tag, ".mem_we"}, 32'(mem_we), 32'(v.e_we));
      if (v.e_we) check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(v.e_wdata));
      for (int k = 1; k <= 40 && !got; k++) begin
        if (v.ack_at == k) begin
          mem_ack = 1'b1; mem_rdata = v.rdata;
        end else begin
          mem_rdata = 16'($urandom);
        end
        step();
        mem_ack = 1'b0;
        lat++;
        if (valid_o) got = 1'b1;
        else check({tag, ".req_held"}, 32'({mem_req, ready_o, mem_addr}),
                   32'({1'b1, 1'b0, v.e_maddr}));
      end
      if (!got) $display("FAIL %s.bound: no valid_o within 40 cycles", tag);
      check({tag, ".req_drop"}, 32'(mem_req), 32'd0);
    end
    check({tag, ".valid"}, 32'(valid_o), 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'(v.e_lat));
    check({tag, ".fault"}, 32'(fault_o), 32'(v.e_fault));
    if (!v.e_fault) check({tag, ".data"}, 32'(data_out_o), 32'(v.e_data));
    check({tag, ".reg_write"}, 32'(reg_write_o), 32'(v.e_rw));
    check({tag, ".reg_dest"}, 32'(reg_dest_o), 32'(v.dest));
    check({tag, ".setPC"}, 32'(setPC_o), 32'(v.e_spc));
    check({tag, ".ready_after"}, 32'(ready_o), 32'd1);
    step();
    check({tag, ".pulse"}, 32'(valid_o), 32'd0);
    $display("txn %s rd=%0d wr=%0d byte=%0d addr=%h ack_at=%0d lat=%0d data=%h fault=%0d",
             tag, v.rd, v.wr, v.byt, v.addr, v.ack_at, lat, data_out_o, fault_o);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    byte_i = 1'b0; addr_i = 16'h0; store_data_i = 16'h0; reg_write_i = 2'b00;
    reg_dest_i = 4'h0; setPC_i = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0;

    //          rd wr by addr      sdata     rw     dst   spc ack rdata     lat e_data    e_rw   spc flt maddr     be     wdata     we
    tbl[0] = '{0, 0, 0, 16'h1234, 16'h0000, 2'b11, 4'd5, 0,  0, 16'h0000, 1, 16'h1234, 2'b11, 0, 0, 16'h0000, 2'b00, 16'h0000, 0};
    tbl[1] = '{1, 0, 0, 16'h0101, 16'h0000, 2'b11, 4'd3, 0,  3, 16'hBEEF, 4, 16'hBEEF, 2'b11, 0, 0, 16'h0100, 2'b11, 16'h0000, 0};
    tbl[2] = '{1, 0, 1, 16'h2001, 16'h0000, 2'b01, 4'd7, 0,  1, 16'hA55A, 2, 16'h00A5, 2'b01, 0, 0, 16'h2001, 2'b10, 16'h0000, 0};
    tbl[3] = '{1, 0, 1, 16'h2000, 16'h0000, 2'b01, 4'd8, 0,  2, 16'hA55A, 3, 16'h005A, 2'b01, 0, 0, 16'h2000, 2'b01, 16'h0000, 0};
    tbl[4] = '{0, 1, 1, 16'h0040, 16'h12CD, 2'b00, 4'd0, 0,  1, 16'hFFFF, 2, 16'h0040, 2'b00, 0, 0, 16'h0040, 2'b01, 16'hCDCD, 1};
    tbl[5] = '{1, 0, 0, 16'h0800, 16'h0000, 2'b11, 4'd2, 1,  0, 16'h0000, 5, 16'h0000, 2'b00, 0, 1, 16'h0800, 2'b11, 16'h0000, 0};
    tbl[6] = '{1, 0, 0, 16'h0800, 16'h0000, 2'b11, 4'd2, 0,  4, 16'h1357, 5, 16'h1357, 2'b11, 0, 0, 16'h0800, 2'b11, 16'h0000, 0};
    tbl[7] = '{1, 1, 0, 16'h0333, 16'hCAFE, 2'b00, 4'd1, 0,  2, 16'h9999, 3, 16'h0333, 2'b00, 0, 0, 16'h0332, 2'b11, 16'hCAFE, 1};
    tbl[8] = '{0, 0, 0, 16'h4000, 16'h0000, 2'b00, 4'd0, 1,  0, 16'h0000, 1, 16'h4000, 2'b00, 1, 0, 16'h0000, 2'b00, 16'h0000, 0};

    step(); step();
    check("rst.outputs", 32'({valid_o, reg_write_o, reg_dest_o, setPC_o, fault_o,
                              mem_req, mem_we, mem_be}), 32'd0);
    check("rst.data", 32'(data_out_o), 32'd0);
    check("rst.mem_addr", 32'(mem_addr), 32'd0);
    check("rst.mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst.ready", 32'(ready_o), 32'd1);
    reset = 1'b0;
    step();

    for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Stray ack while idle must not produce a result.
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    check("stray_ack.valid", 32'(valid_o), 32'd0);
    check("stray_ack.ready", 32'(ready_o), 32'd1);
    $display("txn stray_ack valid=%0d", valid_o);

    // Reset two cycles into an access: req drops at once, no result follows.
    valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; byte_i = 1'b0;
    addr_i = 16'h0F00; reg_write_i = 2'b11; reg_dest_i = 4'd9;
    step();
    valid_i = 1'b0;
    step();
    check("rst_mid.req_before", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid.req_now", 32'(mem_req), 32'd0);
    check("rst_mid.ready", 32'(ready_o), 32'd1);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ack = (i == 0);
      step();
      check("rst_mid.no_valid", 32'(valid_o), 32'd0);
    end
    mem_ack = 1'b0;
    $display("txn reset_mid_access req=%0d valid=%0d", mem_req, valid_o);
    run_txn(tbl[0], "post_reset");

    // Random transactions against the model, with idle gaps.
    for (int n = 0; n < 60; n++) begin
      v.rd = 1'b0; v.wr = 1'b0;
      case ($urandom_range(0, 3))
        0: ;
        1: v.rd = 1'b1;
        2: v.wr = 1'b1;
        default: begin v.rd = 1'b1; v.wr = ($urandom_range(0, 3) == 0); end
      endcase
      v.byt    = 1'($urandom);
      v.addr   = 16'($urandom);
      v.sdata  = 16'($urandom);
      v.dest   = 4'($urandom);
      v.rw     = v.wr ? 2'b00 : 2'($urandom);
      v.spc    = v.wr ? 1'b0 : 1'($urandom_range(0, 3) == 0);
      v.ack_at = $urandom_range(0, TO + 2);
      v.rdata  = 16'($urandom);
      v = model(v);
      run_txn(v, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 2) == 0) begin
        mem_ack = 1'($urandom);
        step();
        mem_ack = 1'b0;
        check("rnd.idle_valid", 32'(valid_o), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
